// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full/level logic for an asynchronous FIFO.
// Keeps a binary write pointer plus its Gray image for the read-domain synchronizer,
// and derives full, almost-full, a conservative fill level and a sticky overflow flag
// from the Gray read pointer already synchronized into this clock domain.
// addr_width must be at least 2 so the full comparison has both MSBs to invert.
module fifo_wptr_full #(
  parameter int unsigned addr_width = 4,
  parameter int unsigned af_margin  = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  winc,
  input  logic [addr_width:0]   wq2_rptr,
  input  logic                  ovf_clr,
  output logic                  w_accept,
  output logic [addr_width-1:0] waddr,
  output logic [addr_width:0]   wptr,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [addr_width:0]   wlevel,
  output logic                  woverflow
);

  localparam int unsigned Depth = 2 ** addr_width;
  localparam int unsigned Msb   = addr_width;
  // Level at or above which almost-full is flagged.
  localparam logic [addr_width:0] AfThresh = (addr_width + 1)'(Depth - af_margin);

  logic [addr_width:0] wbin_q, wbin_d;
  logic [addr_width:0] wptr_q, wgray_d;
  logic                wfull_q, wfull_d;
  logic                walmost_full_q, walmost_full_d;
  logic [addr_width:0] wlevel_q, level_d;
  logic                woverflow_q, woverflow_d;
  logic [addr_width:0] rbin_sync;
  logic [addr_width:0] rptr_full_pat;

  // A write is taken whenever the producer asks and the registered full flag allows it.
  assign w_accept = winc & ~wfull_q;

  // Gray-to-binary conversion of the synchronized read pointer: bit i is the XOR of
  // all Gray bits at or above i.
  always_comb begin
    rbin_sync = '0;
    for (int i = 0; i <= int'(addr_width); i++) begin
      rbin_sync[i] = ^(wq2_rptr >> i);
    end
  end

  // Read pointer as the write pointer would look exactly one lap ahead: top two Gray
  // bits inverted, the rest unchanged.
  assign rptr_full_pat = {~wq2_rptr[Msb:Msb-1], wq2_rptr[Msb-2:0]};

  // Next-state for pointers and flags; full and level look at the post-increment
  // pointer so full asserts on the very edge that accepts the last free slot.
  always_comb begin
    wbin_d         = wbin_q + (addr_width + 1)'(w_accept);
    wgray_d        = (wbin_d >> 1) ^ wbin_d;
    wfull_d        = (wgray_d == rptr_full_pat);
    // Modular subtraction stays correct across pointer wrap; stale read pointer only
    // ever makes the level look higher than it really is.
    level_d        = wbin_d - rbin_sync;
    walmost_full_d = (level_d >= AfThresh);
    // A new overflow wins over a simultaneous clear.
    woverflow_d    = (winc & wfull_q) | (woverflow_q & ~ovf_clr);
  end

  // State registers; asynchronous reset discards all pointer state immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wbin_q         <= '0;
      wptr_q         <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      wlevel_q       <= '0;
      woverflow_q    <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wptr_q         <= wgray_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      wlevel_q       <= level_d;
      woverflow_q    <= woverflow_d;
    end
  end

  assign waddr        = wbin_q[addr_width-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign wlevel       = wlevel_q;
  assign woverflow    = woverflow_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full with addr_width=4, af_margin=2.
module tb_fifo_wptr_full;

  logic       clk;
  logic       resetn;
  logic       winc;
  logic [4:0] wq2_rptr;
  logic       ovf_clr;
  logic       w_accept;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       woverflow;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_wptr_full #(
    .addr_width(4),
    .af_margin (2)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .winc        (winc),
    .wq2_rptr    (wq2_rptr),
    .ovf_clr     (ovf_clr),
    .w_accept    (w_accept),
    .waddr       (waddr),
    .wptr        (wptr),
    .wfull       (wfull),
    .walmost_full(walmost_full),
    .wlevel      (wlevel),
    .woverflow   (woverflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       winc;
    logic [4:0] rptr;
    logic       clr;
    logic       acc;    // combinational, checked before the edge
    logic [3:0] waddr;  // registered values, checked after the edge
    logic [4:0] wptr;
    logic       full;
    logic       af;
    logic [4:0] level;
    logic       ovf;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] gray(input logic [4:0] b);
    return (b >> 1) ^ b;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    resetn   = 1'b0;
    winc     = 1'b0;
    ovf_clr  = 1'b0;
    wq2_rptr = 5'b00000;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    winc     = v.winc;
    wq2_rptr = v.rptr;
    ovf_clr  = v.clr;
    #1;
    chk({tag, ".w_accept"}, 32'(w_accept), 32'(v.acc));
    @(posedge clk);
    #1;
    chk({tag, ".waddr"}, 32'(waddr), 32'(v.waddr));
    chk({tag, ".wptr"}, 32'(wptr), 32'(v.wptr));
    chk({tag, ".wfull"}, 32'(wfull), 32'(v.full));
    chk({tag, ".walmost_full"}, 32'(walmost_full), 32'(v.af));
    chk({tag, ".wlevel"}, 32'(wlevel), 32'(v.level));
    chk({tag, ".woverflow"}, 32'(woverflow), 32'(v.ovf));
  endtask

  initial begin
    logic [4:0] prev_wptr;
    logic [4:0] kb;

    // Fill to full from empty with the read pointer parked at 0.
    //           winc rptr      clr acc waddr  wptr      full af  level     ovf
    vecs[0]  = '{1'b1, 5'b00000, 1'b0, 1'b1, 4'd1,  5'b00001, 1'b0, 1'b0, 5'd1,  1'b0};
    vecs[1]  = '{1'b1, 5'b00000, 1'b0, 1'b1, 4'd2,  5'b00011, 1'b0, 1'b0, 5'd2,  1'b0};
    vecs[2]  = '{1'b1, 5'b00000, 1'b0, 1'b1, 4'd3,  5'b00010, 1'b0, 1'b0, 5'd3,  1'b0};
    vecs[3]  = '{1'b1, 5'b00000, 1'b0, 1'b1, 4'd4,  5'b00110, 1'b0, 1'b0, 5'd4,  1'b0};
    vecs[4]  = '{1'b1, 5'b00000, 1'b0, 1'b1, 4'd5,  5'b00111, 1'b0, 1'b0, 5'd5,  1'b0};
    vecs[5]  = '{1'b1, 5'b00000, 1'b0, 1'b1, 4'd6,  5'b00101, 1'b0, 1'b0, 5'd6,  1'b0};
    vecs[6]  = '{1'b1, 5'b00000, 1'b0, 1'b1, 4'd7,  5'b00100, 1'b0, 1'b0, 5'd7,  1'b0};
    vecs[7]  = '{1'b1, 5'b00000, 1'b0, 1'b1, 4'd8,  5'b01100, 1'b0, 1'b0, 5'd8,  1'b0};
    vecs[8]  = '{1'b1, 5'b00000, 1'b0, 1'b1, 4'd9,  5'b01101, 1'b0, 1'b0, 5'd9,  1'b0};
    vecs[9]  = '{1'b1, 5'b00000, 1'b0, 1'b1, 4'd10, 5'b01111, 1'b0, 1'b0, 5'd10, 1'b0};
    vecs[10] = '{1'b1, 5'b00000, 1'b0, 1'b1, 4'd11, 5'b01110, 1'b0, 1'b0, 5'd11, 1'b0};
    vecs[11] = '{1'b1, 5'b00000, 1'b0, 1'b1, 4'd12, 5'b01010, 1'b0, 1'b0, 5'd12, 1'b0};
    vecs[12] = '{1'b1, 5'b00000, 1'b0, 1'b1, 4'd13, 5'b01011, 1'b0, 1'b0, 5'd13, 1'b0};
    vecs[13] = '{1'b1, 5'b00000, 1'b0, 1'b1, 4'd14, 5'b01001, 1'b0, 1'b1, 5'd14, 1'b0};
    vecs[14] = '{1'b1, 5'b00000, 1'b0, 1'b1, 4'd15, 5'b01000, 1'b0, 1'b1, 5'd15, 1'b0};
    vecs[15] = '{1'b1, 5'b00000, 1'b0, 1'b1, 4'd0,  5'b11000, 1'b1, 1'b1, 5'd16, 1'b0};
    // Write while full: rejected, overflow sets.
    vecs[16] = '{1'b1, 5'b00000, 1'b0, 1'b0, 4'd0,  5'b11000, 1'b1, 1'b1, 5'd16, 1'b1};
    // Overflow again together with clear: stays set.
    vecs[17] = '{1'b1, 5'b00000, 1'b1, 1'b0, 4'd0,  5'b11000, 1'b1, 1'b1, 5'd16, 1'b1};
    // Clear with no write: drops.
    vecs[18] = '{1'b0, 5'b00000, 1'b1, 1'b0, 4'd0,  5'b11000, 1'b1, 1'b1, 5'd16, 1'b0};
    // Reader moves to Gray 1: full releases without a write.
    vecs[19] = '{1'b0, 5'b00001, 1'b0, 1'b0, 4'd0,  5'b11000, 1'b0, 1'b1, 5'd15, 1'b0};
    // One more write fills it again (wbin 17, Gray 11001).
    vecs[20] = '{1'b1, 5'b00001, 1'b0, 1'b1, 4'd1,  5'b11001, 1'b1, 1'b1, 5'd16, 1'b0};
    // Reader to Gray 2 (binary 2): level 15, not full.
    vecs[21] = '{1'b0, 5'b00011, 1'b0, 1'b0, 4'd1,  5'b11001, 1'b0, 1'b1, 5'd15, 1'b0};

    resetn   = 1'b0;
    winc     = 1'b0;
    ovf_clr  = 1'b0;
    wq2_rptr = 5'b00000;
    #1;
    chk("por.wptr", 32'(wptr), 32'd0);
    chk("por.wlevel", 32'(wlevel), 32'd0);
    do_reset();

    for (int i = 0; i < 22; i++) apply_vec(i, vecs[i]);

    // Asynchronous reset mid-stream, away from any clock edge.
    @(posedge clk);
    #2;
    winc   = 1'b0;
    resetn = 1'b0;
    #1;
    chk("arst.waddr", 32'(waddr), 32'd0);
    chk("arst.wptr", 32'(wptr), 32'd0);
    chk("arst.wfull", 32'(wfull), 32'd0);
    chk("arst.walmost_full", 32'(walmost_full), 32'd0);
    chk("arst.wlevel", 32'(wlevel), 32'd0);
    chk("arst.woverflow", 32'(woverflow), 32'd0);
    chk("arst.w_accept", 32'(w_accept), 32'd0);

    // First update happens on the first edge after release.
    @(negedge clk);
    resetn   = 1'b1;
    wq2_rptr = 5'b00000;
    winc     = 1'b1;
    @(posedge clk);
    #1;
    chk("rel.wlevel", 32'(wlevel), 32'd1);
    chk("rel.wptr", 32'(wptr), 32'd1);

    // Wrap: prefill two entries, then keep the reader two behind for 40 writes.
    do_reset();
    @(negedge clk);
    winc     = 1'b1;
    wq2_rptr = 5'b00000;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("wrap.pre_level", 32'(wlevel), 32'd2);
    prev_wptr = wptr;
    for (int k = 3; k <= 42; k++) begin
      @(negedge clk);
      wq2_rptr = gray(5'(k - 2));
      @(posedge clk);
      #1;
      kb = 5'(k);
      chk($sformatf("wrap%0d.wptr", k), 32'(wptr), 32'(gray(kb)));
      chk($sformatf("wrap%0d.onebit", k), 32'($countones(wptr ^ prev_wptr)), 32'd1);
      chk($sformatf("wrap%0d.waddr", k), 32'(waddr), 32'(kb[3:0]));
      chk($sformatf("wrap%0d.wfull", k), 32'(wfull), 32'd0);
      chk($sformatf("wrap%0d.wlevel", k), 32'(wlevel), 32'd2);
      prev_wptr = wptr;
    end
    @(negedge clk);
    winc = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_wptr_full.md
FIFO_WPTR_FULL -- requirements
Module: fifo_wptr_full

Interface
REQ-001 Parameter: addr_width, default 4, FIFO address width; depth = 2**addr_width entries.
REQ-002 Parameter: af_margin, default 2, almost-full threshold measured as free entries remaining.
REQ-003 Port: clk  input  1  write-domain clock; all state updates on posedge.
REQ-004 Port: resetn  input  1  asynchronous, active-low reset.
REQ-005 Port: winc  input  1  write request from producer.
REQ-006 Port: wq2_rptr  input  addr_width+1  Gray read pointer, already double-synchronized into this clock domain.
REQ-007 Port: ovf_clr  input  1  clears the sticky overflow flag.
REQ-008 Port: w_accept  output  1  write accepted this cycle (combinational).
REQ-009 Port: waddr  output  addr_width  RAM write address.
REQ-010 Port: wptr  output  addr_width+1  registered Gray write pointer, sent to the read-domain synchronizer.
REQ-011 Port: wfull  output  1  registered full flag.
REQ-012 Port: walmost_full  output  1  registered; level >= depth - af_margin.
REQ-013 Port: wlevel  output  addr_width+1  registered conservative fill level, 0..depth.
REQ-014 Port: woverflow  output  1  sticky flag; a write was attempted while full.

Function
REQ-015 Internal binary pointer wbin has width addr_width+1; waddr SHALL equal wbin[addr_width-1:0].
REQ-016 w_accept SHALL equal winc & ~wfull; no other qualifier.
REQ-017 wbin_next = wbin + w_accept, modulo 2**(addr_width+1); wbin SHALL update to wbin_next every clock.
REQ-018 wgray_next = (wbin_next >> 1) ^ wbin_next; wptr SHALL register wgray_next, so wptr changes at most one bit per clock.
REQ-019 wfull SHALL register (wgray_next == {~wq2_rptr[MSB:MSB-1], wq2_rptr[MSB-2:0]}), MSB = addr_width.
REQ-020 wfull SHALL assert on the clock edge that accepts the depth-th outstanding write, with no extra-cycle lag.
REQ-021 wfull SHALL deassert on the first edge where wq2_rptr no longer satisfies REQ-019, with or without winc.
REQ-022 rbin_sync SHALL be the combinational Gray-to-binary conversion of wq2_rptr.
REQ-023 wlevel SHALL register (wbin_next - rbin_sync) modulo 2**(addr_width+1).
REQ-024 wlevel can be pessimistic, never optimistic, because synchronizer latency delays wq2_rptr.
REQ-025 walmost_full SHALL register (level_next >= depth - af_margin), where level_next is the value being loaded into wlevel.
REQ-026 Pointer wrap-around: wbin rolls from 2**(addr_width+1)-1 to 0 with no special case; full and level SHALL stay correct across the wrap.
REQ-027 woverflow SHALL set on any edge where winc & wfull is true.
REQ-028 woverflow SHALL clear on an edge with ovf_clr=1 and no new overflow.
REQ-029 Simultaneous set (REQ-027) and ovf_clr SHALL leave woverflow set.
REQ-030 A rejected write SHALL change no pointer, wlevel or waddr.

Reset
REQ-031 On resetn=0, asynchronously and independent of clk, the following SHALL all be 0: wbin, wptr, wfull, walmost_full, wlevel, woverflow.
REQ-032 Reset asserted mid-operation SHALL discard all pointer state immediately.
REQ-033 Release of reset is synchronous to clk; the first update occurs on the first posedge with resetn=1.
REQ-034 w_accept during reset follows REQ-016 with wfull=0; the producer must hold winc=0.

Verification (addr_width=4, af_margin=2)
REQ-035 Reset check: assert resetn=0 mid-stream, no clock -> all outputs 0 immediately; waddr=0.
REQ-036 Fill to full: wq2_rptr=5'b00000, winc=1 for 16 cycles -> wlevel counts 1..16; walmost_full rises with wlevel=14; wfull=1 and wptr=5'b11000 after the 16th edge.
REQ-037 Write while full: after the fill, one extra winc -> w_accept=0, waddr stays 0, wptr stays 5'b11000, woverflow=1.
REQ-038 Release full: drive wq2_rptr=5'b00001 (Gray 1) with winc=0 -> wfull=0 and wlevel=15 after the next edge.
REQ-039 Overflow clear race: hold winc=1 while full and pulse ovf_clr=1 -> woverflow stays 1. Then winc=0 with ovf_clr=1 -> woverflow=0.
REQ-040 Wrap: 40 writes with the read pointer tracking two behind -> wbin wraps 31->0, wptr takes Gray values only with single-bit changes, wfull never asserts, wlevel stays 2.
